// File: rtl/apb_comp.sv
// apb_comp -- APB completer with 64 x 32-bit word storage and programmable wait states.
//
// Ports:
//   pclk      in   sole clock, rising edge
//   preset_n  in   synchronous active-low reset
//   paddr     in   byte address; word index is paddr[7:2]
//   pprot     in   protection attributes (accepted, no effect)
//   psel      in   completer select
//   penable   in   ACCESS phase indicator
//   pwrite    in   1 = write, 0 = read
//   pwdata    in   write data
//   pstrb     in   write byte strobes (ignored on reads)
//   prdata    out  read data; 0 except during a good read completion
//   pready    out  transfer completion
//   pslverr   out  transfer error (misaligned or address >= 0x100)
//
// Handshake: a transfer completes on the rising edge where pready=1. pready
// is asserted only in the ACCESS state with psel and penable high once the
// wait counter reaches WAIT_STATES. Write data commits and read data is valid
// on that same completing edge; bus values present at that edge are used.
// The FSM state is held in the signal 'state' for checker binding.
module apb_comp #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int WAIT_STATES = 1
) (
  input  logic                    pclk,
  input  logic                    preset_n,
  input  logic [ADDR_WIDTH-1:0]   paddr,
  input  logic [2:0]              pprot,
  input  logic                    psel,
  input  logic                    penable,
  input  logic                    pwrite,
  input  logic [DATA_WIDTH-1:0]   pwdata,
  input  logic [DATA_WIDTH/8-1:0] pstrb,
  output logic [DATA_WIDTH-1:0]   prdata,
  output logic                    pready,
  output logic                    pslverr
);

  localparam int         NBYTES = DATA_WIDTH / 8;
  localparam logic [3:0] WS     = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t                  state;
  logic [3:0]              count;
  logic [DATA_WIDTH-1:0]   mem [64];
  logic [5:0]              idx;
  logic                    addr_err;
  logic                    unused_prot;

  // Protection attributes are accepted but never affect behaviour.
  assign unused_prot = ^pprot;

  assign idx      = paddr[7:2];
  assign addr_err = (paddr[1:0] != 2'b00) || (|paddr[ADDR_WIDTH-1:8]);

  // Gated by preset_n so the outputs are quiet during the reset cycle itself,
  // even though the registered state only clears at the reset edge. This
  // also keeps a transfer caught by reset from completing or writing.
  assign pready  = preset_n && (state == ACCESS) && psel && penable && (count == WS);
  assign pslverr = pready && addr_err;
  assign prdata  = (pready && !pwrite && !addr_err) ? mem[idx] : '0;

  always_ff @(posedge pclk) begin
    if (!preset_n) begin
      state <= IDLE;
      count <= '0;
      for (int i = 0; i < 64; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (!psel) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            // penable high while idle is not a valid start; stay put.
            if (!penable) state <= SETUP;
          end
          SETUP: begin
            state <= ACCESS;
            count <= '0;
          end
          ACCESS: begin
            if (pready) begin
              state <= IDLE;
            end else if (count != WS) begin
              // Holds at WS if penable drops, so the counter never wraps.
              count <= count + 4'd1;
            end
          end
          default: state <= IDLE;
        endcase
      end

      if (pready && pwrite && !addr_err) begin
        for (int b = 0; b < NBYTES; b++) begin
          if (pstrb[b]) mem[idx][8*b +: 8] <= pwdata[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_apb_comp.sv
// tb_apb_comp -- directed testbench for apb_comp.
// Three instances share clock and reset: index 0 has WAIT_STATES=1,
// index 1 has WAIT_STATES=0, index 2 has WAIT_STATES=3.
// Latency is counted in bus cycles with penable=1; the completer spends one
// of those in its SETUP state, so completion lands on cycle WAIT_STATES+2.
module tb_apb_comp;

  localparam int NI = 3;

  logic        pclk = 1'b0;
  logic        preset_n;
  logic [31:0] paddr_a   [NI];
  logic [2:0]  pprot_a   [NI];
  logic        psel_a    [NI];
  logic        penable_a [NI];
  logic        pwrite_a  [NI];
  logic [31:0] pwdata_a  [NI];
  logic [3:0]  pstrb_a   [NI];
  logic [31:0] prdata_a  [NI];
  logic        pready_a  [NI];
  logic        pslverr_a [NI];

  int checks = 0;
  int errors = 0;

  // Clock and reset
  always #5 pclk = ~pclk;

  apb_comp #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .WAIT_STATES(1)) dut_ws1 (
    .pclk(pclk), .preset_n(preset_n), .paddr(paddr_a[0]), .pprot(pprot_a[0]),
    .psel(psel_a[0]), .penable(penable_a[0]), .pwrite(pwrite_a[0]),
    .pwdata(pwdata_a[0]), .pstrb(pstrb_a[0]), .prdata(prdata_a[0]),
    .pready(pready_a[0]), .pslverr(pslverr_a[0])
  );

  apb_comp #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .WAIT_STATES(0)) dut_ws0 (
    .pclk(pclk), .preset_n(preset_n), .paddr(paddr_a[1]), .pprot(pprot_a[1]),
    .psel(psel_a[1]), .penable(penable_a[1]), .pwrite(pwrite_a[1]),
    .pwdata(pwdata_a[1]), .pstrb(pstrb_a[1]), .prdata(prdata_a[1]),
    .pready(pready_a[1]), .pslverr(pslverr_a[1])
  );

  apb_comp #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .WAIT_STATES(3)) dut_ws3 (
    .pclk(pclk), .preset_n(preset_n), .paddr(paddr_a[2]), .pprot(pprot_a[2]),
    .psel(psel_a[2]), .penable(penable_a[2]), .pwrite(pwrite_a[2]),
    .pwdata(pwdata_a[2]), .pstrb(pstrb_a[2]), .prdata(prdata_a[2]),
    .pready(pready_a[2]), .pslverr(pslverr_a[2])
  );

  // ---------------- driver tasks ----------------

  task automatic bus_idle(input int k);
    @(negedge pclk);
    psel_a[k]    = 1'b0;
    penable_a[k] = 1'b0;
    pwrite_a[k]  = 1'b0;
  endtask

  // One full transfer: SETUP then ACCESS until pready. Returns the captured
  // read data, error flag and the number of penable-high cycles. Outputs
  // must stay quiet in every non-completing cycle.
  task automatic apb_xfer(input int k, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] strb,
                          input logic [2:0] prot, output logic [31:0] rdata,
                          output logic err, output int lat);
    @(negedge pclk);
    psel_a[k]    = 1'b1;
    penable_a[k] = 1'b0;
    pwrite_a[k]  = wr;
    paddr_a[k]   = addr;
    pwdata_a[k]  = wdata;
    pstrb_a[k]   = strb;
    pprot_a[k]   = prot;
    #1;
    checks++;
    if (pready_a[k] !== 1'b0 || prdata_a[k] !== 32'h0 || pslverr_a[k] !== 1'b0) begin
      errors++;
      $display("FAIL setup_quiet[%0d] addr=%h: pready=%b prdata=%h pslverr=%b, required 0/0/0",
               k, addr, pready_a[k], prdata_a[k], pslverr_a[k]);
    end
    @(negedge pclk);
    penable_a[k] = 1'b1;
    lat   = 0;
    rdata = 'x;
    err   = 1'bx;
    while (1) begin
      lat++;
      #1;
      if (pready_a[k] === 1'b1) begin
        rdata = prdata_a[k];
        err   = pslverr_a[k];
        break;
      end
      checks++;
      if (prdata_a[k] !== 32'h0 || pslverr_a[k] !== 1'b0) begin
        errors++;
        $display("FAIL wait_quiet[%0d] addr=%h: prdata=%h pslverr=%b, required 0/0",
                 k, addr, prdata_a[k], pslverr_a[k]);
      end
      if (lat >= 40) begin
        errors++;
        $display("FAIL timeout[%0d] addr=%h: no pready after %0d cycles, required %0d",
                 k, addr, lat, 40);
        break;
      end
      @(negedge pclk);
    end
  endtask

  // ---------------- scenario tasks ----------------

  task automatic test_reset();
    preset_n = 1'b0;
    // Junk on the bus during reset must be ignored.
    psel_a[0] = 1'b1; penable_a[0] = 1'b1; pwrite_a[0] = 1'b1;
    paddr_a[0] = 32'h84; pwdata_a[0] = 32'hFFFF_FFFF; pstrb_a[0] = 4'hF;
    repeat (5) begin
      @(negedge pclk);
      #1;
      checks++;
      if (pready_a[0] !== 1'b0 || pslverr_a[0] !== 1'b0 || prdata_a[0] !== 32'h0) begin
        errors++;
        $display("FAIL reset_outputs: pready=%b pslverr=%b prdata=%h, required 0/0/0",
                 pready_a[0], pslverr_a[0], prdata_a[0]);
      end
    end
    @(negedge pclk);
    preset_n = 1'b1;
    for (int k = 0; k < NI; k++) begin
      psel_a[k] = 1'b0; penable_a[k] = 1'b0; pwrite_a[k] = 1'b0;
    end
  endtask

  task automatic test_first_read();
    logic [31:0] rd; logic er; int lat;
    apb_xfer(0, 1'b0, 32'h84, 32'h0, 4'h0, 3'b000, rd, er, lat);
    checks++;
    if (rd !== 32'h0 || er !== 1'b0) begin
      errors++;
      $display("FAIL first_read: prdata=%h pslverr=%b, required 00000000/0", rd, er);
    end
    checks++;
    if (lat !== 3) begin
      errors++;
      $display("FAIL first_read_latency: %0d penable cycles, required 3", lat);
    end
    bus_idle(0);
  endtask

  task automatic test_penable_in_idle();
    logic [31:0] rd; logic er; int lat;
    @(negedge pclk);
    psel_a[0] = 1'b1; penable_a[0] = 1'b1; pwrite_a[0] = 1'b1;
    paddr_a[0] = 32'h40; pwdata_a[0] = 32'h5555_5555; pstrb_a[0] = 4'hF;
    repeat (3) begin
      #1;
      checks++;
      if (pready_a[0] !== 1'b0) begin
        errors++;
        $display("FAIL idle_penable_pready: pready=%b, required 0", pready_a[0]);
      end
      @(negedge pclk);
    end
    psel_a[0] = 1'b0; penable_a[0] = 1'b0;
    apb_xfer(0, 1'b0, 32'h40, 32'h0, 4'h0, 3'b000, rd, er, lat);
    checks++;
    if (rd !== 32'h0 || er !== 1'b0) begin
      errors++;
      $display("FAIL idle_penable_nowrite: prdata=%h pslverr=%b, required 00000000/0", rd, er);
    end
    bus_idle(0);
  endtask

  task automatic test_write_read();
    logic [31:0] rd; logic er; int lat;
    apb_xfer(0, 1'b1, 32'h84, 32'h1234_5678, 4'hF, 3'b010, rd, er, lat);
    checks++;
    if (er !== 1'b0 || rd !== 32'h0) begin
      errors++;
      $display("FAIL write_84: pslverr=%b prdata=%h, required 0/00000000", er, rd);
    end
    // Back-to-back read of the word just written.
    apb_xfer(0, 1'b0, 32'h84, 32'h0, 4'h0, 3'b010, rd, er, lat);
    checks++;
    if (rd !== 32'h1234_5678 || er !== 1'b0) begin
      errors++;
      $display("FAIL read_84: prdata=%h pslverr=%b, required 12345678/0", rd, er);
    end
    bus_idle(0);
  endtask

  task automatic test_strobes();
    logic [31:0] rd; logic er; int lat;
    apb_xfer(0, 1'b1, 32'h10, 32'hFFFF_FFFF, 4'hF, 3'b000, rd, er, lat);
    apb_xfer(0, 1'b1, 32'h10, 32'h0000_00AA, 4'h1, 3'b000, rd, er, lat);
    apb_xfer(0, 1'b0, 32'h10, 32'h0, 4'h0, 3'b000, rd, er, lat);
    checks++;
    if (rd !== 32'hFFFF_FFAA || er !== 1'b0) begin
      errors++;
      $display("FAIL strobe_byte0: prdata=%h pslverr=%b, required ffffffaa/0", rd, er);
    end
    // Zero strobes: completes without error and changes nothing.
    apb_xfer(0, 1'b1, 32'h10, 32'h1111_2222, 4'h0, 3'b111, rd, er, lat);
    checks++;
    if (er !== 1'b0) begin
      errors++;
      $display("FAIL strobe_zero_err: pslverr=%b, required 0", er);
    end
    // Upper two bytes only.
    apb_xfer(0, 1'b1, 32'h10, 32'h1234_0000, 4'hC, 3'b000, rd, er, lat);
    // Strobes are ignored on reads.
    apb_xfer(0, 1'b0, 32'h10, 32'h0, 4'h5, 3'b000, rd, er, lat);
    checks++;
    if (rd !== 32'h1234_FFAA || er !== 1'b0) begin
      errors++;
      $display("FAIL strobe_upper: prdata=%h pslverr=%b, required 1234ffaa/0", rd, er);
    end
    bus_idle(0);
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic er; int lat;
    // Both addresses alias word 0 through paddr[7:2]; neither may write it.
    apb_xfer(0, 1'b1, 32'h102, 32'hCAFE_F00D, 4'hF, 3'b000, rd, er, lat);
    checks++;
    if (er !== 1'b1 || lat !== 3) begin
      errors++;
      $display("FAIL err_write_102: pslverr=%b lat=%0d, required 1/3", er, lat);
    end
    apb_xfer(0, 1'b1, 32'h200, 32'hCAFE_F00D, 4'hF, 3'b000, rd, er, lat);
    checks++;
    if (er !== 1'b1) begin
      errors++;
      $display("FAIL err_write_200: pslverr=%b, required 1", er);
    end
    apb_xfer(0, 1'b1, 32'h0000_0003, 32'hCAFE_F00D, 4'hF, 3'b000, rd, er, lat);
    checks++;
    if (er !== 1'b1) begin
      errors++;
      $display("FAIL err_write_003: pslverr=%b, required 1", er);
    end
    apb_xfer(0, 1'b0, 32'h00, 32'h0, 4'h0, 3'b000, rd, er, lat);
    checks++;
    if (rd !== 32'h0 || er !== 1'b0) begin
      errors++;
      $display("FAIL err_storage_kept: prdata=%h pslverr=%b, required 00000000/0", rd, er);
    end
    // Errored read: error flagged, data forced to zero.
    apb_xfer(0, 1'b0, 32'h8000_0084, 32'h0, 4'h0, 3'b000, rd, er, lat);
    checks++;
    if (rd !== 32'h0 || er !== 1'b1) begin
      errors++;
      $display("FAIL err_read_high: prdata=%h pslverr=%b, required 00000000/1", rd, er);
    end
    bus_idle(0);
  endtask

  task automatic test_reset_mid_transfer();
    logic [31:0] rd; logic er; int lat;
    @(negedge pclk);
    psel_a[0] = 1'b1; penable_a[0] = 1'b0; pwrite_a[0] = 1'b1;
    paddr_a[0] = 32'h20; pwdata_a[0] = 32'hDEAD_BEEF; pstrb_a[0] = 4'hF;
    @(negedge pclk);
    penable_a[0] = 1'b1;
    @(negedge pclk);
    @(negedge pclk);
    // Third penable cycle would complete; reset lands on it instead.
    preset_n = 1'b0;
    #1;
    checks++;
    if (pready_a[0] !== 1'b0) begin
      errors++;
      $display("FAIL reset_abort_pready: pready=%b, required 0", pready_a[0]);
    end
    @(negedge pclk);
    @(negedge pclk);
    preset_n = 1'b1;
    psel_a[0] = 1'b0; penable_a[0] = 1'b0;
    apb_xfer(0, 1'b0, 32'h20, 32'h0, 4'h0, 3'b000, rd, er, lat);
    checks++;
    if (rd !== 32'h0 || er !== 1'b0) begin
      errors++;
      $display("FAIL reset_abort_read_20: prdata=%h pslverr=%b, required 00000000/0", rd, er);
    end
    // Word 0x84 held 12345678 before the reset and must now be clear.
    apb_xfer(0, 1'b0, 32'h84, 32'h0, 4'h0, 3'b000, rd, er, lat);
    checks++;
    if (rd !== 32'h0) begin
      errors++;
      $display("FAIL reset_clears_84: prdata=%h, required 00000000", rd);
    end
    bus_idle(0);
  endtask

  task automatic test_back_to_back(input int k, input int ws);
    logic [31:0] rd; logic er; int lat;
    logic [31:0] exp_q[$];
    logic [31:0] pat, exp_d;
    for (int i = 0; i < 64; i++) begin
      pat = (32'(i) * 32'h0101_0101) ^ 32'h5A00_00A5 ^ (32'(ws) << 12);
      exp_q.push_back(pat);
      apb_xfer(k, 1'b1, 32'(i * 4), pat, 4'hF, 3'b000, rd, er, lat);
      checks++;
      if (er !== 1'b0 || lat !== ws + 2) begin
        errors++;
        $display("FAIL b2b_write[ws=%0d] i=%0d: pslverr=%b lat=%0d, required 0/%0d",
                 ws, i, er, lat, ws + 2);
      end
    end
    for (int i = 0; i < 64; i++) begin
      apb_xfer(k, 1'b0, 32'(i * 4), 32'h0, 4'h0, 3'b000, rd, er, lat);
      exp_d = exp_q.pop_front();
      checks++;
      if (rd !== exp_d || er !== 1'b0 || lat !== ws + 2) begin
        errors++;
        $display("FAIL b2b_read[ws=%0d] i=%0d: prdata=%h pslverr=%b lat=%0d, required %h/0/%0d",
                 ws, i, rd, er, lat, exp_d, ws + 2);
      end
    end
    bus_idle(k);
  endtask

  // ---------------- sequence and report ----------------

  initial begin
    preset_n = 1'b0;
    for (int k = 0; k < NI; k++) begin
      paddr_a[k] = '0; pprot_a[k] = '0; psel_a[k] = 1'b0; penable_a[k] = 1'b0;
      pwrite_a[k] = 1'b0; pwdata_a[k] = '0; pstrb_a[k] = '0;
    end
    test_reset();
    test_first_read();
    test_penable_in_idle();
    test_write_read();
    test_strobes();
    test_errors();
    test_reset_mid_transfer();
    test_back_to_back(1, 0);
    test_back_to_back(2, 3);
    repeat (2) @(negedge pclk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_comp.md
APB_COMP -- requirements
Module: apb_comp

Interface
REQ-001 The block SHALL expose parameter DATA_WIDTH, default 32, the PWDATA/PRDATA width; only 32 is required.
REQ-002 The block SHALL expose parameter ADDR_WIDTH, default 32, the PADDR width.
REQ-003 The block SHALL expose parameter WAIT_STATES, default 1, the number of ACCESS cycles with PREADY low before completion (range 0-15).
REQ-004 The block SHALL have one clock and a synchronous, active-low reset; the port list SHALL be, clock and reset first:
- pclk  in  1  sole clock; all logic on rising edge.
- preset_n  in  1  reset; synchronous, active-low.
- paddr  in  ADDR_WIDTH  byte address.
- pprot  in  3  protection attributes; accepted, not checked.
- psel  in  1  completer select.
- penable  in  1  ACCESS phase indicator.
- pwrite  in  1  1 = write, 0 = read.
- pwdata  in  DATA_WIDTH  write data.
- pstrb  in  DATA_WIDTH/8  write byte strobes.
- prdata  out  DATA_WIDTH  read data.
- pready  out  1  transfer completion.
- pslverr  out  1  transfer error.

Function
REQ-005 Storage SHALL be 64 x 32-bit words at byte addresses 0x00-0xFC, with word index paddr[7:2].
REQ-006 The FSM SHALL have states IDLE, SETUP and ACCESS.
- IDLE to SETUP: psel=1 and penable=0.
- SETUP to ACCESS: unconditionally on the next edge.
- ACCESS to IDLE: when pready=1 at the edge.
- Any state to IDLE: psel=0.
REQ-007 penable=1 while the FSM is in IDLE SHALL be ignored: no pready, no storage access.
REQ-008 A wait counter SHALL clear on entry to ACCESS and increment each ACCESS cycle while pready=0.
REQ-009 pready SHALL equal (state==ACCESS && psel && penable && count==WAIT_STATES); pready SHALL be 0 at all other times.
REQ-010 With WAIT_STATES=N, pready SHALL rise in the (N+1)th ACCESS cycle; N=0 SHALL complete in the first ACCESS cycle.
REQ-011 An error SHALL be flagged when paddr[1:0]!=0 or paddr >= 0x100.
REQ-012 pslverr SHALL equal pready AND the error condition, and SHALL be 0 whenever pready=0.
REQ-013 A write SHALL commit at the edge where pready=1, pwrite=1 and there is no error: byte i SHALL be updated iff pstrb[i]=1.
REQ-014 A write with pstrb=0 SHALL complete normally with no storage change and no error.
REQ-015 An errored write SHALL leave storage unchanged.
REQ-016 prdata SHALL present the addressed word while pready=1 and pwrite=0 with no error; prdata SHALL be 0 in every other cycle.
REQ-017 pstrb SHALL be ignored on reads, and pprot SHALL never influence behaviour.
REQ-018 Control and address changes during ACCESS SHALL NOT be checked; the values present at the completing edge SHALL be used.
REQ-019 Back-to-back transfers SHALL be supported: psel held high with penable=0 after completion SHALL enter SETUP directly.
REQ-020 A read and a write to the same word in consecutive transfers SHALL return the newly written data.

Reset
REQ-021 When preset_n=0 at a rising edge, the FSM SHALL enter IDLE and the wait counter SHALL clear.
REQ-022 When preset_n=0 at a rising edge, all 64 words SHALL clear to 0.
REQ-023 During reset, pready, pslverr and prdata SHALL be 0.
REQ-024 Reset asserted mid-transfer SHALL abort the transfer, with no storage update and no pready; the requester SHALL restart with a SETUP after release.
REQ-025 While preset_n=0, all inputs SHALL be ignored.

Verification
REQ-026 Reset for 5 cycles, then read 0x84 -> prdata=0x0, pslverr=0, pready high in the 2nd ACCESS cycle (WAIT_STATES=1).
REQ-027 Write 0x84 data 0x12345678, pstrb=0xF, pprot=3'b010, then read 0x84 -> prdata=0x12345678, pslverr=0 on both transfers.
REQ-028 Write 0x10 data 0xFFFFFFFF pstrb=0xF, then write 0x10 data 0x000000AA pstrb=0x1, then read 0x10 -> prdata=0xFFFFFFAA.
REQ-029 Write 0x102 and write 0x200 -> pslverr=1 with pready=1; a following read of 0x00 -> prdata unchanged, pslverr=0.
REQ-030 Assert preset_n=0 during the ACCESS phase of a write to 0x20 data 0xDEADBEEF, release, then read 0x20 -> prdata=0x0.
REQ-031 Run back-to-back writes to 0x00-0xFC and read them back with WAIT_STATES=0 and WAIT_STATES=3 -> all data matches, pready high for exactly 1 cycle per transfer.
